// File: rtl/emulator_launch_ctrl.sv
// Start/done handshake initiator for the emulator core: issues one job per start,
// times it, and reports elapsed cycles plus a timeout flag on a valid/ready port.
module emulator_launch_ctrl #(
  parameter int unsigned CYCLE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [CYCLE_W-1:0] timeout_limit,
  output logic               dut_valid,
  input  logic               dut_ready,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               done_timeout,
  output logic [CYCLE_W-1:0] done_cycles,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CYCLE_W-1:0] cnt;
  logic [CYCLE_W-1:0] limit_q;
  logic [CYCLE_W-1:0] cnt_inc;
  logic               timeout_hit;

  // Saturating count for the current cycle; a zero limit never times out.
  always_comb begin
    cnt_inc     = (&cnt) ? cnt : cnt + CYCLE_W'(1);
    timeout_hit = (limit_q != '0) && (cnt_inc == limit_q);
  end

  assign start_ready = (state == IDLE) && dut_ready && !reset;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dut_valid    <= 1'b0;
      done_valid   <= 1'b0;
      done_timeout <= 1'b0;
      done_cycles  <= '0;
      cnt          <= '0;
      limit_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            limit_q   <= timeout_limit;
            cnt       <= '0;
            dut_valid <= 1'b1;
            state     <= REQ;
          end
        end
        // Timeout beats acceptance here; the core may still be busy afterwards.
        REQ: begin
          cnt <= cnt_inc;
          if (timeout_hit) begin
            dut_valid    <= 1'b0;
            done_valid   <= 1'b1;
            done_timeout <= 1'b1;
            done_cycles  <= limit_q;
            state        <= DONE;
          end else if (!dut_ready) begin
            dut_valid <= 1'b0;
            state     <= RUN;
          end
        end
        // Completion beats a coincident timeout.
        RUN: begin
          cnt <= cnt_inc;
          if (dut_ready) begin
            done_valid   <= 1'b1;
            done_timeout <= 1'b0;
            done_cycles  <= cnt_inc;
            state        <= DONE;
          end else if (timeout_hit) begin
            done_valid   <= 1'b1;
            done_timeout <= 1'b1;
            done_cycles  <= limit_q;
            state        <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
